// File: rtl/sat_portfolio_ctrl.sv
// rtl/sat_portfolio_ctrl.sv - portfolio controller racing NUM_NODES sat_node solvers on one problem
//
// Launches every solver node with one start, takes the verdict and assignment of the
// first node to finish (lowest index wins ties), aborts the others and enforces a
// RUN-cycle timeout. Presents the same result surface as a single solver node.
//
// Optional feature macro: PORTFOLIO_XCHECK_EN
//   When defined, a cross-check window of XCHECK_WINDOW cycles follows the first finish.
//   Any other node that finishes inside the window with a different verdict raises
//   result_conflict. Undefined: no result_conflict port and RUN goes straight to DONE.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   synchronous reset, active-high
//   start           in   launch request, honoured in IDLE and DONE only
//   node_start      out  one-cycle launch pulse to all nodes
//   node_abort      out  one-cycle abort pulse to nodes that lost the race
//   node_done       in   per-node done level, held until the next node_start
//   node_sat        in   per-node verdict, valid with node_done
//   node_values     in   node i assignment at [i*NUM_VARS +: NUM_VARS]
//   done            out  result valid (level, held until next start)
//   result_sat      out  1 = SAT, 0 = UNSAT or timeout
//   result_timeout  out  budget exhausted before any node finished
//   winner_id       out  index of the node that supplied the result
//   values          out  winner assignment (zero for UNSAT/timeout), bit 0 = var 1
//   cycle_count     out  RUN cycles elapsed, saturating, frozen at done
//   result_conflict out  (PORTFOLIO_XCHECK_EN only) disagreeing verdict seen in window
//   state_out       out  FSM state: IDLE=0 RUN=1 XCHECK=2 DONE=3

module sat_portfolio_ctrl #(
  parameter int NUM_NODES      = 4,
  parameter int NUM_VARS       = 16,
  parameter int CYCLE_W        = 32,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int XCHECK_WINDOW  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic [NUM_NODES-1:0]          node_start,
  output logic [NUM_NODES-1:0]          node_abort,
  input  logic [NUM_NODES-1:0]          node_done,
  input  logic [NUM_NODES-1:0]          node_sat,
  input  logic [NUM_NODES*NUM_VARS-1:0] node_values,
  output logic                          done,
  output logic                          result_sat,
  output logic                          result_timeout,
  output logic [$clog2(NUM_NODES):0]    winner_id,
  output logic [NUM_VARS-1:0]           values,
  output logic [CYCLE_W-1:0]            cycle_count,
`ifdef PORTFOLIO_XCHECK_EN
  output logic                          result_conflict,
`endif
  output logic [2:0]                    state_out
);

  localparam int                 ID_W        = $clog2(NUM_NODES) + 1;
  localparam logic [CYCLE_W-1:0] TIMEOUT_VAL = CYCLE_W'(TIMEOUT_CYCLES);
  localparam bit                 TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  if (NUM_NODES < 1 || NUM_NODES > 16 || XCHECK_WINDOW < 1) begin : g_bad_params
    $error("sat_portfolio_ctrl: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_XCHECK = 3'd2,
    S_DONE   = 3'd3
  } state_t;

  state_t state_q, state_d;

  logic [NUM_NODES-1:0] node_start_d, node_abort_d;
  logic                 done_d, result_sat_d, result_timeout_d;
  logic [ID_W-1:0]      winner_id_d;
  logic [NUM_VARS-1:0]  values_d;
  logic [CYCLE_W-1:0]   cycle_count_d, count_inc;

  // During the launch-pulse cycle the nodes have not yet seen node_start, so their
  // done levels still belong to the previous problem and must not be taken as a finish.
  logic [NUM_NODES-1:0] done_live;
  assign done_live = (|node_start) ? '0 : node_done;

  // Fixed-priority pick of the lowest-index finisher.
  logic [ID_W-1:0]     first_id;
  logic                first_sat;
  logic [NUM_VARS-1:0] first_vals;

  always_comb begin
    first_id   = '0;
    first_sat  = 1'b0;
    first_vals = '0;
    for (int i = NUM_NODES - 1; i >= 0; i--) begin
      if (done_live[i]) begin
        first_id   = ID_W'(i);
        first_sat  = node_sat[i];
        first_vals = node_values[i*NUM_VARS +: NUM_VARS];
      end
    end
  end

  assign count_inc = (&cycle_count) ? cycle_count : cycle_count + CYCLE_W'(1);

`ifdef PORTFOLIO_XCHECK_EN
  localparam logic [31:0] WIN_LAST = 32'(XCHECK_WINDOW - 1);

  logic [31:0]          win_cnt_q, win_cnt_d;
  logic                 conflict_q, conflict_d;
  logic [NUM_NODES-1:0] win_onehot, dissent;

  assign win_onehot = NUM_NODES'(1) << winner_id;
  // Any other node currently done whose verdict differs from the latched winner.
  assign dissent    = node_done & ~win_onehot & (node_sat ^ {NUM_NODES{result_sat}});
`else
  logic [NUM_NODES-1:0] first_onehot;
  assign first_onehot = NUM_NODES'(1) << first_id;
`endif

  always_comb begin
    state_d          = state_q;
    node_start_d     = '0;
    node_abort_d     = '0;
    done_d           = done;
    result_sat_d     = result_sat;
    result_timeout_d = result_timeout;
    winner_id_d      = winner_id;
    values_d         = values;
    cycle_count_d    = cycle_count;
`ifdef PORTFOLIO_XCHECK_EN
    win_cnt_d        = win_cnt_q;
    conflict_d       = conflict_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d          = S_RUN;
          node_start_d     = '1;
          done_d           = 1'b0;
          result_sat_d     = 1'b0;
          result_timeout_d = 1'b0;
          winner_id_d      = '0;
          values_d         = '0;
          cycle_count_d    = '0;
`ifdef PORTFOLIO_XCHECK_EN
          win_cnt_d        = '0;
          conflict_d       = 1'b0;
`endif
        end
      end

      S_RUN: begin
        // A finish takes priority over a timeout reached in the same cycle.
        if (|done_live) begin
          cycle_count_d = count_inc;
          result_sat_d  = first_sat;
          winner_id_d   = first_id;
          values_d      = first_sat ? first_vals : '0;
`ifdef PORTFOLIO_XCHECK_EN
          state_d       = S_XCHECK;
          win_cnt_d     = '0;
`else
          state_d       = S_DONE;
          done_d        = 1'b1;
          node_abort_d  = ~first_onehot;
`endif
        end else if (TIMEOUT_EN && cycle_count == TIMEOUT_VAL) begin
          state_d          = S_DONE;
          done_d           = 1'b1;
          result_timeout_d = 1'b1;
          result_sat_d     = 1'b0;
          values_d         = '0;
          winner_id_d      = '0;
          node_abort_d     = '1;
        end else begin
          cycle_count_d = count_inc;
        end
      end

`ifdef PORTFOLIO_XCHECK_EN
      S_XCHECK: begin
        cycle_count_d = count_inc;
        if (|dissent) conflict_d = 1'b1;
        if (win_cnt_q == WIN_LAST) begin
          state_d      = S_DONE;
          done_d       = 1'b1;
          // Winner holds done, so it is never aborted; neither is anyone else already done.
          node_abort_d = ~node_done & ~win_onehot;
        end else begin
          win_cnt_d = win_cnt_q + 32'd1;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      node_start     <= '0;
      node_abort     <= '0;
      done           <= 1'b0;
      result_sat     <= 1'b0;
      result_timeout <= 1'b0;
      winner_id      <= '0;
      values         <= '0;
      cycle_count    <= '0;
`ifdef PORTFOLIO_XCHECK_EN
      win_cnt_q      <= '0;
      conflict_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      node_start     <= node_start_d;
      node_abort     <= node_abort_d;
      done           <= done_d;
      result_sat     <= result_sat_d;
      result_timeout <= result_timeout_d;
      winner_id      <= winner_id_d;
      values         <= values_d;
      cycle_count    <= cycle_count_d;
`ifdef PORTFOLIO_XCHECK_EN
      win_cnt_q      <= win_cnt_d;
      conflict_q     <= conflict_d;
`endif
    end
  end

`ifdef PORTFOLIO_XCHECK_EN
  assign result_conflict = conflict_q;
`endif
  assign state_out = state_q;

endmodule

// File: tb/tb_sat_portfolio_ctrl.sv
// tb/tb_sat_portfolio_ctrl.sv - scoreboard bench for sat_portfolio_ctrl with a race-outcome model
`timescale 1ns/1ps
module tb_sat_portfolio_ctrl;
  localparam int NN  = 4;
  localparam int NV  = 16;
  localparam int CW  = 32;
  localparam int TMO = 100;
  localparam int XW  = 8;
  localparam int INF = 1000;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [NN-1:0]     node_start, node_abort, node_done, node_sat;
  logic [NN*NV-1:0]  node_values;
  logic              done, result_sat, result_timeout;
  logic [2:0]        winner_id;
  logic [NV-1:0]     values;
  logic [CW-1:0]     cycle_count;
  logic [2:0]        state_out;
`ifdef PORTFOLIO_XCHECK_EN
  logic              result_conflict;
`endif

  always #5 clk = ~clk;

  sat_portfolio_ctrl #(
    .NUM_NODES(NN), .NUM_VARS(NV), .CYCLE_W(CW), .TIMEOUT_CYCLES(TMO), .XCHECK_WINDOW(XW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .node_start(node_start), .node_abort(node_abort),
    .node_done(node_done), .node_sat(node_sat), .node_values(node_values),
    .done(done), .result_sat(result_sat), .result_timeout(result_timeout),
    .winner_id(winner_id), .values(values), .cycle_count(cycle_count),
`ifdef PORTFOLIO_XCHECK_EN
    .result_conflict(result_conflict),
`endif
    .state_out(state_out)
  );

  typedef struct {
    logic [2:0]    wid;
    logic          sat;
    logic          tmo;
    logic [NV-1:0] vals;
    logic [CW-1:0] cnt;
    logic [NN-1:0] abort;
    logic          conflict;
  } exp_t;

  exp_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  // Per-run scenario: RUN cycle at which each node raises done (INF = never), verdict, assignment.
  int            t_fin[NN];
  logic          sat_v[NN];
  logic [NV-1:0] val_v[NN];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outcome of the race: earliest finisher wins (lowest index on ties) if it finishes no
  // later than the budget; otherwise the run times out.
  function automatic exp_t model();
    exp_t e;
    int tmin = INF;
    int w = 0;
    for (int i = 0; i < NN; i++) if (t_fin[i] < tmin) begin tmin = t_fin[i]; w = i; end
    e.conflict = 1'b0;
    if (tmin <= TMO) begin
      e.wid  = 3'(w);
      e.sat  = sat_v[w];
      e.tmo  = 1'b0;
      e.vals = sat_v[w] ? val_v[w] : '0;
`ifdef PORTFOLIO_XCHECK_EN
      e.cnt   = CW'(tmin + 1 + XW);
      e.abort = '0;
      for (int i = 0; i < NN; i++) begin
        if (i != w) begin
          if (t_fin[i] <= tmin + XW) begin
            if (sat_v[i] != sat_v[w]) e.conflict = 1'b1;
          end else begin
            e.abort[i] = 1'b1;
          end
        end
      end
`else
      e.cnt      = CW'(tmin + 1);
      e.abort    = '1;
      e.abort[w] = 1'b0;
`endif
    end else begin
      e.wid = '0; e.sat = 1'b0; e.tmo = 1'b1; e.vals = '0;
      e.cnt = CW'(TMO); e.abort = '1;
    end
    return e;
  endfunction

  task automatic run_case(input bit poke_start, input int rst_at);
    int k;
    int guard;
    node_done = '0;
    for (int i = 0; i < NN; i++) begin
      node_sat[i] = sat_v[i];
      node_values[i*NV +: NV] = val_v[i];
    end
    if (rst_at < 0) exp_q.push_back(model());
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0; k = 0;
    chk("start_pulse", 32'(node_start), 32'hF);
    chk("clear_done", 32'(done), 0);
    chk("clear_count", cycle_count, 0);
    chk("clear_values", 32'(values), 0);
    chk("clear_winner", 32'(winner_id), 0);
    guard = 0;
    while (!done && guard < 400) begin
      @(posedge clk); #1; k++; guard++;
      if (rst_at >= 0 && k == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("midrst_state", 32'(state_out), 0);
        chk("midrst_abort", 32'(node_abort), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_count", cycle_count, 0);
        node_done = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_stays_idle", 32'(state_out), 0);
        return;
      end
      start = (poke_start && k == 3);
      for (int i = 0; i < NN; i++) node_done[i] = (t_fin[i] <= k);
    end
    start = 1'b0;
    if (!done) chk("done_within_budget", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    for (int i = 0; i < NN; i++) begin
      t_fin[i] = INF; sat_v[i] = 1'b0; val_v[i] = 16'($urandom);
    end
  endtask

  // Monitor: compares each result as done rises, and polices abort pulses.
  initial begin
    bit   done_q;
    bit   clr_pend;
    exp_t e;
    done_q = 1'b0; clr_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_q = 1'b0; clr_pend = 1'b0;
      end else begin
        if (done && !done_q) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("winner_id", 32'(winner_id), 32'(e.wid));
            chk("result_sat", 32'(result_sat), 32'(e.sat));
            chk("result_timeout", 32'(result_timeout), 32'(e.tmo));
            chk("values", 32'(values), 32'(e.vals));
            chk("cycle_count", cycle_count, e.cnt);
            chk("node_abort", 32'(node_abort), 32'(e.abort));
`ifdef PORTFOLIO_XCHECK_EN
            chk("result_conflict", 32'(result_conflict), 32'(e.conflict));
`endif
          end
          clr_pend = 1'b1;
        end else if (clr_pend) begin
          chk("abort_one_cycle", 32'(node_abort), 0);
          clr_pend = 1'b0;
        end else if (node_abort != '0) begin
          chk("spurious_abort", 32'(node_abort), 0);
        end
        done_q = done;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; node_done = '0; node_sat = '0; node_values = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 0);
    chk("rst_sat", 32'(result_sat), 0);
    chk("rst_timeout", 32'(result_timeout), 0);
    chk("rst_winner", 32'(winner_id), 0);
    chk("rst_values", 32'(values), 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_state", 32'(state_out), 0);
    chk("rst_node_start", 32'(node_start), 0);
    chk("rst_node_abort", 32'(node_abort), 0);
`ifdef PORTFOLIO_XCHECK_EN
    chk("rst_conflict", 32'(result_conflict), 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Node 2 SAT at cycle 40; a start mid-run must be ignored.
    set_idle(); t_fin[2] = 40; sat_v[2] = 1'b1; val_v[2] = 16'hA5A5;
    run_case(1'b1, -1);

    // Nodes 1 and 3 together, node 1 UNSAT wins on priority.
    set_idle(); t_fin[1] = 30; sat_v[1] = 1'b0; t_fin[3] = 30; sat_v[3] = 1'b1;
    run_case(1'b0, -1);

    // No finisher: timeout.
    set_idle();
    run_case(1'b0, -1);

    // Finish exactly at the budget beats the timeout.
    set_idle(); t_fin[2] = TMO; sat_v[2] = 1'b1;
    run_case(1'b0, -1);

    // Reset at RUN cycle 10: back to IDLE, no abort, no result.
    set_idle(); t_fin[0] = 50; sat_v[0] = 1'b1;
    run_case(1'b0, 10);

`ifdef PORTFOLIO_XCHECK_EN
    set_idle(); t_fin[0] = 20; sat_v[0] = 1'b1; t_fin[1] = 24; sat_v[1] = 1'b0;
    run_case(1'b0, -1);
    set_idle(); t_fin[0] = 20; sat_v[0] = 1'b1; t_fin[1] = 29; sat_v[1] = 1'b0;
    run_case(1'b0, -1);
`endif

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NN; i++) begin
        t_fin[i] = ($urandom_range(0, 3) == 0) ? INF : int'($urandom_range(1, 120));
        sat_v[i] = 1'($urandom_range(0, 1));
        val_v[i] = 16'($urandom);
      end
      run_case(1'b0, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
